ref_row_rd_ctrl: RTL and testbench
==================================

REF_ROW_RD_CTRL -- requirements
Module: ref_row_rd_ctrl

Interface
REQ-001 Parameter AREA1_ROWS, default 10, number of sub-area-1 rows (1..16).
REQ-002 Parameter AREA2_ROWS, default 32, number of sub-area-2 rows (1..118).
REQ-003 Parameter BANK_OFFSET, default 10, first sub-area-2 row count value and bank-rebase constant (0..15).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a search-window read pass.
REQ-007 abort  input  1  synchronous cancel of the pass in progress.
REQ-008 rd_ready  input  1  reference-memory read port accepts the current request.
REQ-009 rd_en  output  1  read request valid.
REQ-010 rdR_sel  output  4  reference row-bank select, 16 banks.
REQ-011 rd_addr  output  3  row index within the selected bank.
REQ-012 sub_area1_row_count  output  7  current sub-area-1 row.
REQ-013 sub_area2_row_count  output  7  current sub-area-2 row.
REQ-014 busy  output  1  high in states AREA1 and AREA2.
REQ-015 done  output  1  one-cycle pulse when a pass completes normally.

Function
REQ-016 The FSM SHALL have states IDLE, AREA1, AREA2 and DONE; all outputs SHALL be registered.
REQ-017 IDLE->AREA1 on start; start SHALL be ignored in every other state.
REQ-018 On entry to AREA1, sub_area1_row_count SHALL be 0; on entry to AREA2, sub_area2_row_count SHALL be BANK_OFFSET.
REQ-019 rd_en SHALL be 1 in AREA1 and AREA2 and 0 in IDLE and DONE; the first rd_en is one cycle after start is sampled.
REQ-020 A transfer SHALL occur on a cycle with rd_en=1 and rd_ready=1; with rd_ready=0, counts, rdR_sel and rd_addr SHALL hold and rd_en SHALL stay 1.
REQ-021 In AREA1, rdR_sel SHALL be sub_area1_row_count[3:0] and rd_addr SHALL be sub_area1_row_count[6:4].
REQ-022 In AREA2, diff = sub_area2_row_count - BANK_OFFSET in 7-bit unsigned arithmetic. rdR_sel SHALL be diff[3:0], i.e. modulo 16 with wrap, never saturation. rd_addr SHALL be diff[6:4].
REQ-023 Each transfer SHALL increment the active count by 1.
REQ-024 A transfer at sub_area1_row_count = AREA1_ROWS-1 SHALL move to AREA2 with no idle cycle; AREA1 and AREA2 requests SHALL be back to back.
REQ-025 A transfer at sub_area2_row_count = BANK_OFFSET+AREA2_ROWS-1 SHALL move to DONE.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 Outside its own sub-area state, each count SHALL hold its last value until re-initialised by the next pass.
REQ-028 abort in AREA1 or AREA2 SHALL enter IDLE next cycle with rd_en=0 and no done pulse; abort SHALL have priority over a simultaneous transfer.
REQ-029 abort in IDLE or DONE SHALL be ignored; a done pulse already in progress SHALL complete.
REQ-030 A pass SHALL comprise exactly AREA1_ROWS+AREA2_ROWS transfers.

Reset
REQ-031 rst SHALL override start and abort.
REQ-032 While rst is high, the FSM SHALL be IDLE and all outputs SHALL be 0.
REQ-033 rst asserted mid-pass SHALL discard the pass without a done pulse; a start is accepted from the first cycle after rst deasserts.

Verification
REQ-034 Defaults, rd_ready=1, start pulse -> 42 consecutive rd_en cycles: rdR_sel 0..9, then 0..15, 0..15; done pulses on the cycle after the last transfer.
REQ-035 AREA2 with rd_ready=1 -> sub_area2_row_count=12 gives rdR_sel=2; 18 gives 8; 25 gives 15 with rd_addr=0; 26 gives 0 with rd_addr=1.
REQ-036 rd_ready low for 3 cycles at sub_area2_row_count=12 -> rd_en=1, count and rdR_sel=2 held 3 cycles, then advance to 13/3.
REQ-037 abort together with rd_ready at sub_area1_row_count=5 -> next cycle IDLE, rd_en=0, busy=0, no done; a following start restarts from row 0.
REQ-038 rst pulse in AREA2 -> all outputs 0 the next cycle; a start during busy causes no restart or count disturbance.
REQ-039 BANK_OFFSET=0, AREA1_ROWS=1, AREA2_ROWS=1 -> exactly 2 transfers, rdR_sel 0 then 0, then done.

Source files
------------

// File: rtl/ref_row_rd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ref_row_rd_ctrl                                            |
// | Description : Search-window reference row read controller. A start      |
// |               pulse launches one pass that reads AREA1_ROWS sub-area-1   |
// |               rows and then AREA2_ROWS sub-area-2 rows back to back,     |
// |               presenting a 16-way bank select plus an in-bank row        |
// |               index per request. A single-cycle done pulse marks normal  |
// |               completion. abort cancels a pass without a done pulse.     |
// | Ports       : clk, rst          - clock, sync active-high reset          |
// |               start, abort      - pass launch / cancel                   |
// |               rd_ready          - read port accepts current request      |
// |               rd_en             - read request valid                     |
// |               rdR_sel, rd_addr  - bank select / row index in bank        |
// |               sub_area1/2_row_count - current row of each sub-area       |
// |               busy, done        - pass active / pass complete pulse      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ref_row_rd_ctrl #(
   parameter int unsigned AREA1_ROWS  = 10,
   parameter int unsigned AREA2_ROWS  = 32,
   parameter int unsigned BANK_OFFSET = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       rd_ready,
   output logic       rd_en,
   output logic [3:0] rdR_sel,
   output logic [2:0] rd_addr,
   output logic [6:0] sub_area1_row_count,
   output logic [6:0] sub_area2_row_count,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_AREA1 = 2'd1;
   localparam logic [1:0] c_AREA2 = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   localparam logic [6:0] c_BASE    = 7'(BANK_OFFSET);
   localparam logic [6:0] c_A1_LAST = 7'(AREA1_ROWS - 1);
   // Row counts are 7 bits wide; the terminal value wraps the same way the
   // counter does.
   localparam logic [6:0] c_A2_LAST = 7'(BANK_OFFSET + AREA2_ROWS - 1);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic       r_rd_en, r_busy, r_done;
   logic [3:0] r_sel;
   logic [2:0] r_addr;
   logic [6:0] r_cnt1, r_cnt2;

   logic       w_rd_en_nxt, w_busy_nxt, w_done_nxt;
   logic [3:0] w_sel_nxt;
   logic [2:0] w_addr_nxt;
   logic [6:0] w_cnt1_nxt, w_cnt2_nxt, w_diff;
   logic       w_xfer;

   // rd_en is high exactly in AREA1/AREA2, so it doubles as the request
   // qualifier for a transfer.
   assign w_xfer = r_rd_en & rd_ready;

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
         r_rd_en <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sel   <= 4'd0;
         r_addr  <= 3'd0;
         r_cnt1  <= 7'd0;
         r_cnt2  <= 7'd0;
      end else begin
         r_state <= w_state_nxt;
         r_rd_en <= w_rd_en_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_sel   <= w_sel_nxt;
         r_addr  <= w_addr_nxt;
         r_cnt1  <= w_cnt1_nxt;
         r_cnt2  <= w_cnt2_nxt;
      end
   end

   // Next-state logic; abort outranks a simultaneous transfer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (start) w_state_nxt = c_AREA1;
         end
         c_AREA1: begin
            if (abort)
               w_state_nxt = c_IDLE;
            else if (w_xfer && (r_cnt1 == c_A1_LAST))
               w_state_nxt = c_AREA2;
         end
         c_AREA2: begin
            if (abort)
               w_state_nxt = c_IDLE;
            else if (w_xfer && (r_cnt2 == c_A2_LAST))
               w_state_nxt = c_DONE;
         end
         c_DONE:  w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Next-output logic. Outputs are derived from the next state and next
   // counts so every port comes straight from a flop.
   always_comb begin
      w_cnt1_nxt = r_cnt1;
      w_cnt2_nxt = r_cnt2;
      w_sel_nxt  = r_sel;
      w_addr_nxt = r_addr;
      w_diff     = 7'd0;

      case (r_state)
         c_IDLE: begin
            if (start) w_cnt1_nxt = 7'd0;
         end
         c_AREA1: begin
            if (!abort && w_xfer) begin
               w_cnt1_nxt = r_cnt1 + 7'd1;
               if (r_cnt1 == c_A1_LAST) w_cnt2_nxt = c_BASE;
            end
         end
         c_AREA2: begin
            if (!abort && w_xfer) w_cnt2_nxt = r_cnt2 + 7'd1;
         end
         default: ;
      endcase

      w_rd_en_nxt = (w_state_nxt == c_AREA1) || (w_state_nxt == c_AREA2);
      w_busy_nxt  = w_rd_en_nxt;
      w_done_nxt  = (w_state_nxt == c_DONE);

      // Bank select wraps modulo 16; the upper bits of the row offset pick
      // the row within the bank. Outside the read states they hold.
      if (w_state_nxt == c_AREA1) begin
         w_sel_nxt  = w_cnt1_nxt[3:0];
         w_addr_nxt = w_cnt1_nxt[6:4];
      end else if (w_state_nxt == c_AREA2) begin
         w_diff     = w_cnt2_nxt - c_BASE;
         w_sel_nxt  = w_diff[3:0];
         w_addr_nxt = w_diff[6:4];
      end
   end

   assign rd_en               = r_rd_en;
   assign busy                = r_busy;
   assign done                = r_done;
   assign rdR_sel             = r_sel;
   assign rd_addr             = r_addr;
   assign sub_area1_row_count = r_cnt1;
   assign sub_area2_row_count = r_cnt2;

endmodule
`default_nettype wire

// File: tb/tb_ref_row_rd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ref_row_rd_ctrl                                         |
// | Description : Self-checking bench for ref_row_rd_ctrl: vector table,     |
// |               directed multi-cycle sequences and randomized stimulus     |
// |               against a transfer-index reference model.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ref_row_rd_ctrl;

   localparam int A1 = 10;
   localparam int A2 = 32;
   localparam int B  = 10;

   logic clk      = 1'b0;
   logic rst      = 1'b1;
   logic start    = 1'b0;
   logic abort    = 1'b0;
   logic rd_ready = 1'b0;
   logic start2   = 1'b0;
   logic ready2   = 1'b0;

   logic       rd_en, busy, done;
   logic [3:0] rdR_sel;
   logic [2:0] rd_addr;
   logic [6:0] c1, c2;

   logic       rd_en2, busy2, done2;
   logic [3:0] rdR_sel2;
   logic [2:0] rd_addr2;
   logic [6:0] c1_2, c2_2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ref_row_rd_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .rd_ready(rd_ready),
      .rd_en(rd_en), .rdR_sel(rdR_sel), .rd_addr(rd_addr),
      .sub_area1_row_count(c1), .sub_area2_row_count(c2),
      .busy(busy), .done(done)
   );

   ref_row_rd_ctrl #(.AREA1_ROWS(1), .AREA2_ROWS(1), .BANK_OFFSET(0)) dut_min (
      .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .rd_ready(ready2),
      .rd_en(rd_en2), .rdR_sel(rdR_sel2), .rd_addr(rd_addr2),
      .sub_area1_row_count(c1_2), .sub_area2_row_count(c2_2),
      .busy(busy2), .done(done2)
   );

   wire [23:0] obs1 = {rd_en, busy, done, rdR_sel, rd_addr, c1, c2};
   wire [23:0] obs2 = {rd_en2, busy2, done2, rdR_sel2, rd_addr2, c1_2, c2_2};

   function automatic logic [23:0] mk(input logic en, input logic bz, input logic dn,
                                      input int sel, input int addr, input int k1, input int k2);
      return {en, bz, dn, 4'(sel), 3'(addr), 7'(k1), 7'(k2)};
   endfunction

   task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got {en,busy,done,sel,addr,c1,c2}=%h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: tracks the pass as a transfer index k. Rows follow from
   // k by arithmetic; counts and select hold whenever no transfer happens.
   logic       m_act = 1'b0, m_dn = 1'b0;
   int         m_k   = 0;
   logic [6:0] m_c1  = '0, m_c2 = '0;
   logic [3:0] m_sel = '0;
   logic [2:0] m_addr = '0;

   always @(posedge clk) begin : model
      int nk;
      int idx;
      if (rst) begin
         m_act <= 1'b0; m_dn <= 1'b0; m_k <= 0;
         m_c1 <= '0; m_c2 <= '0; m_sel <= '0; m_addr <= '0;
      end else if (m_act) begin
         if (abort) begin
            m_act <= 1'b0;
         end else if (rd_ready) begin
            nk = m_k + 1;
            m_k <= nk;
            if (nk <= A1) m_c1 <= 7'(nk);
            if (nk >= A1) m_c2 <= 7'(B + nk - A1);
            if (nk == A1 + A2) begin
               m_act <= 1'b0;
               m_dn  <= 1'b1;
            end else begin
               idx    = (nk < A1) ? nk : nk - A1;
               m_sel  <= 4'(idx % 16);
               m_addr <= 3'((idx / 16) % 8);
            end
         end
      end else if (m_dn) begin
         m_dn <= 1'b0;
      end else if (start) begin
         m_act <= 1'b1; m_k <= 0; m_c1 <= '0; m_sel <= '0; m_addr <= '0;
      end
   end

   typedef struct {
      logic        rst;
      logic        start;
      logic        abort;
      logic        ready;
      logic [23:0] exp;
   } vec_t;

   vec_t tbl[12];

   initial begin
      // rst, start, abort, ready, expected outputs after the edge
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0)};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, mk(0,0,0,0,0,0,0)};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(1,1,0,0,0,0,0)};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1,1,0,1,0,1,0)};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(1,1,0,1,0,1,0)};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1,1,0,2,0,2,0)};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, mk(0,0,0,2,0,2,0)};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, mk(0,0,0,2,0,2,0)};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, mk(1,1,0,0,0,0,0)};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0)};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, mk(1,1,0,0,0,0,0)};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(1,1,0,1,0,1,0)};

      for (int i = 0; i < 12; i++) begin
         rst = tbl[i].rst; start = tbl[i].start;
         abort = tbl[i].abort; rd_ready = tbl[i].ready;
         step();
         chk($sformatf("vec%0d", i), obs1, tbl[i].exp);
      end
      start = 0; abort = 0; rd_ready = 0;
      rst = 1; step(); rst = 0;

      // Full pass with a 3-cycle stall at row 12 and a start while busy
      start = 1; step(); start = 0; rd_ready = 1;
      for (int i = 0; i < A1 + A2; i++) begin
         chk($sformatf("pass%0d", i), obs1,
             mk(1, 1, 0, (i < A1) ? i : (i - A1) % 16, (i < A1) ? 0 : (i - A1) / 16,
                (i < A1) ? i : A1, (i < A1) ? 0 : i));
         if (i == 12) begin
            rd_ready = 0;
            repeat (3) begin
               step();
               chk("stall", obs1, mk(1, 1, 0, 2, 0, 10, 12));
            end
            rd_ready = 1;
         end
         if (i == 20) start = 1;
         step();
         start = 0;
      end
      chk("done_pulse", obs1, mk(0, 0, 1, 15, 1, 10, 42));
      rd_ready = 0; step();
      chk("done_end", obs1, mk(0, 0, 0, 15, 1, 10, 42));

      // Abort together with a ready at row 5, then restart
      start = 1; step(); start = 0; rd_ready = 1;
      repeat (5) step();
      chk("pre_abort", obs1, mk(1, 1, 0, 5, 0, 5, 42));
      abort = 1; step(); abort = 0; rd_ready = 0;
      chk("abort", obs1, mk(0, 0, 0, 5, 0, 5, 42));
      step();
      chk("abort_nodone", obs1, mk(0, 0, 0, 5, 0, 5, 42));
      start = 1; step(); start = 0;
      chk("restart", obs1, mk(1, 1, 0, 0, 0, 0, 42));

      // Reset in AREA2, then an immediate start
      rd_ready = 1; repeat (12) step();
      chk("area2_12", obs1, mk(1, 1, 0, 2, 0, 10, 12));
      rst = 1; step(); rst = 0; rd_ready = 0;
      chk("rst_mid", obs1, mk(0, 0, 0, 0, 0, 0, 0));
      start = 1; step(); start = 0;
      chk("start_after_rst", obs1, mk(1, 1, 0, 0, 0, 0, 0));
      rst = 1; step(); rst = 0;

      // Minimal configuration: one row per sub-area, zero offset
      start2 = 1; ready2 = 1; step(); start2 = 0;
      chk("min_a1", obs2, mk(1, 1, 0, 0, 0, 0, 0));
      step();
      chk("min_a2", obs2, mk(1, 1, 0, 0, 0, 1, 0));
      step();
      chk("min_done", obs2, mk(0, 0, 1, 0, 0, 1, 1));
      step();
      chk("min_idle", obs2, mk(0, 0, 0, 0, 0, 1, 1));
      ready2 = 0;

      // Randomized stimulus against the reference model
      for (int n = 0; n < 3000; n++) begin
         rst      = ($urandom % 150) == 0;
         start    = ($urandom % 6) == 0;
         abort    = ($urandom % 40) == 0;
         rd_ready = ($urandom % 4) != 0;
         step();
         chk("random", obs1, {m_act, m_act, m_dn, m_sel, m_addr, m_c1, m_c2});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
